// File: rtl/led_pwm_driver.sv
// led_pwm_driver: double-buffered LED pin driver with global PWM brightness control.
// Hardware blinking is built only when LED_PWM_DRIVER_BLINK_EN is defined.
module led_pwm_driver #(
    parameter int PRESCALE = 1000,
    parameter int PWM_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] led_in,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_din,
    output logic [15:0] led_out,
    output logic        period_start,
    output logic [7:0]  cfg_rd
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_shadow;
    logic [15:0]         led_shadow;
    logic [7:0]          cfg;
    logic                tick;
    logic                boundary;
    logic                on;
    logic                blink_on;

    assign tick         = (prescaler == PS_LAST);
    assign boundary     = tick && (pwm_cnt == '1);
    assign period_start = boundary;
    assign cfg_rd       = cfg;

    // Max duty is forced on so the last PWM slot never shows a gap.
    assign on = (duty_shadow == '1) || (pwm_cnt < duty_shadow);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg         <= 8'h0F;
            led_shadow  <= '0;
            duty_shadow <= '1;
            led_out     <= '0;
        end else begin
            if (cfg_we) begin
                cfg <= cfg_din;
            end
            // Shadows take the pre-write cfg when a write lands on a boundary.
            if (boundary) begin
                led_shadow  <= led_in;
                duty_shadow <= cfg[PWM_BITS-1:0];
            end
            led_out <= led_shadow & {16{on & blink_on}};
        end
    end

`ifdef LED_PWM_DRIVER_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_phase;
    logic       blink_wrap;
    logic       next_phase;
    logic [3:0] rate;

    assign rate       = cfg[7:4];
    assign blink_wrap = (rate != 4'd0) && (blink_cnt == {rate - 4'd1, 4'hF});
    assign next_phase = blink_wrap ? ~blink_phase : blink_phase;

    // blink_on is only updated at boundaries so a phase flip never cuts a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            blink_on    <= 1'b1;
        end else begin
            if (cfg_we) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (boundary) begin
                blink_cnt   <= blink_wrap ? '0 : blink_cnt + 8'd1;
                blink_phase <= next_phase;
            end
            if (boundary) begin
                blink_on <= cfg_we | (rate == 4'd0) | next_phase;
            end
        end
    end
`else
    assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed self-checking bench for led_pwm_driver with PRESCALE=2, PWM_BITS=4 (32-clk period).
module tb_led_pwm_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led_in;
    logic        cfg_we;
    logic [7:0]  cfg_din;
    logic [15:0] led_out;
    logic        period_start;
    logic [7:0]  cfg_rd;

    int total = 0;
    int bad   = 0;

    led_pwm_driver #(.PRESCALE(2), .PWM_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .led_in       (led_in),
        .cfg_we       (cfg_we),
        .cfg_din      (cfg_din),
        .led_out      (led_out),
        .period_start (period_start),
        .cfg_rd       (cfg_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the cycle right after reset release; the boundary is cycle 31 after it.
    task automatic wait_first_ps(input string tag);
        int n = 0;
        while (period_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 16'(n), 16'd31);
    endtask

    // Called at the negedge of a boundary cycle B; returns at the next boundary B+32.
    // Cycle B+1 still shows the previous period's last slot; cycle B+1+j shows slot (j-1)/2.
    task automatic check_period(input string tag, input logic [15:0] prev_last,
                                input logic [15:0] pat, input int on_clks,
                                input bit wr, input logic [7:0] wdata,
                                input int mid_j, input logic [15:0] mid_pat);
        if (wr) begin
            cfg_we  = 1'b1;
            cfg_din = wdata;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk({tag, "_prev"}, led_out, prev_last);
        chk({tag, "_ps_lo"}, {15'd0, period_start}, 16'd0);
        if (wr) chk({tag, "_cfg_rd"}, {8'd0, cfg_rd}, {8'd0, wdata});
        for (int j = 1; j <= 31; j++) begin
            @(negedge clk);
            chk({tag, "_led"}, led_out, (j <= on_clks) ? pat : 16'h0000);
            chk({tag, "_ps"}, {15'd0, period_start}, (j == 31) ? 16'd1 : 16'd0);
            if (j == mid_j) led_in = mid_pat;
        end
    endtask

    initial begin
        logic [15:0] prev;
        rst     = 1'b1;
        led_in  = 16'h0000;
        cfg_we  = 1'b0;
        cfg_din = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_led", led_out, 16'h0000);
        chk("rst_cfg", {8'd0, cfg_rd}, 16'h000F);
        chk("rst_ps", {15'd0, period_start}, 16'd0);

        // Full duty after reset, no gap across the boundary.
        led_in = 16'h55AA;
        rst    = 1'b0;
        wait_first_ps("first_ps");
        check_period("full0", 16'h0000, 16'h55AA, 32, 1'b0, 8'h00, -1, 16'h0);
        check_period("full1", 16'h55AA, 16'h55AA, 32, 1'b0, 8'h00, -1, 16'h0);

        // Double buffering: a mid-period change waits for the next boundary.
        led_in = 16'h00FF;
        check_period("dbuf0", 16'h55AA, 16'h00FF, 32, 1'b0, 8'h00, 16, 16'hFF00);
        check_period("dbuf1", 16'h00FF, 16'hFF00, 32, 1'b0, 8'h00, -1, 16'h0);

        // Duty 4 written on a boundary: old duty for this period, 8 clk on after.
        led_in = 16'hFFFF;
        check_period("duty_wr", 16'hFF00, 16'hFFFF, 32, 1'b1, 8'h04, -1, 16'h0);
        check_period("duty4a", 16'hFFFF, 16'hFFFF, 8, 1'b0, 8'h00, -1, 16'h0);
        check_period("duty4b", 16'h0000, 16'hFFFF, 8, 1'b0, 8'h00, -1, 16'h0);

        // Duty extremes: 0 is always off, 0F is always on.
        check_period("d0_wr", 16'h0000, 16'hFFFF, 8, 1'b1, 8'h00, -1, 16'h0);
        check_period("duty0", 16'h0000, 16'hFFFF, 0, 1'b0, 8'h00, -1, 16'h0);
        check_period("dF_wr", 16'h0000, 16'hFFFF, 0, 1'b1, 8'h0F, -1, 16'h0);
        check_period("dutyFa", 16'h0000, 16'hFFFF, 32, 1'b0, 8'h00, -1, 16'h0);
        check_period("dutyFb", 16'hFFFF, 16'hFFFF, 32, 1'b0, 8'h00, -1, 16'h0);

        // Blink rate 1: 16 periods lit, 16 dark, then lit again (no effect when not built).
        prev = 16'hFFFF;
        for (int p = 0; p < 33; p++) begin
            bit lit;
`ifdef LED_PWM_DRIVER_BLINK_EN
            lit = (p < 16) || (p >= 32);
`else
            lit = 1'b1;
`endif
            check_period("blink", prev, 16'hFFFF, lit ? 32 : 0, p == 0, 8'h1F, -1, 16'h0);
            prev = lit ? 16'hFFFF : 16'h0000;
        end

        // Mid-period reset at pwm_cnt=7, colliding with a cfg write.
        repeat (15) @(negedge clk);
        chk("pre_rst_led", led_out, 16'hFFFF);
        rst     = 1'b1;
        cfg_we  = 1'b1;
        cfg_din = 8'h33;
        @(negedge clk);
        rst    = 1'b0;
        cfg_we = 1'b0;
        led_in = 16'hA5A5;
        chk("mrst_led", led_out, 16'h0000);
        chk("mrst_cfg", {8'd0, cfg_rd}, 16'h000F);
        chk("mrst_ps", {15'd0, period_start}, 16'd0);
        wait_first_ps("mrst_first_ps");
        check_period("mrst_full", 16'h0000, 16'hA5A5, 32, 1'b0, 8'h00, -1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
